// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one uart_tx datapath among NUM_REQ byte requesters. A round-robin
//   arbiter picks a requester in IDLE. Its byte and the frame format are
//   latched at grant and then held until the frame is finished. Each frame is
//   sequenced as start pulse, wait for tx_done, completion pulse, and then a
//   fixed idle gap before the next arbitration.
//
//   Optional feature macro: UART_TX_SCHED_TIMEOUT_EN
//     defined   : a BUSY watchdog of TIMEOUT_CYC cycles pulses timeout_err and
//                 abandons the frame (no cpl), then runs the normal gap.
//     undefined : no watchdog, BUSY waits for tx_done indefinitely and
//                 timeout_err stays 0.
//
//   state | meaning
//   ------+------------------------------------------------------------------
//   IDLE  | arbitrate among req when enable=1
//   LOAD  | one cycle: gnt/tx_start pulses visible, byte and format latched
//   BUSY  | frame on the wire, waiting for tx_done (or watchdog expiry)
//   GAP   | GAP_CYCLES idle cycles before the next arbitration; the first
//         | GAP cycle carries the cpl (or timeout_err) pulse

module uart_tx_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int GAP_CYCLES  = 16,
   parameter int TIMEOUT_CYC = 4096
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [8*NUM_REQ-1:0]   req_data,
   input  logic [1:0]             cfg_data_bits,
   input  logic                   cfg_stop2,
   input  logic                   cfg_parity_en,
   input  logic                   cfg_parity_even,
   output logic [NUM_REQ-1:0]     gnt,
   output logic [NUM_REQ-1:0]     cpl,
   output logic                   busy,
   output logic [2:0]             owner,
   output logic [7:0]             tx_data,
   output logic [1:0]             tx_data_bit_num,
   output logic                   tx_stop_bit_num,
   output logic                   tx_parity_en,
   output logic                   tx_parity_type,
   output logic                   tx_start,
   input  logic                   tx_done,
   output logic                   timeout_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_BUSY = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   // Gap counter is a down-counter loaded with GAP_CYCLES-1; width never drops to 0.
   localparam int GW = $clog2(GAP_CYCLES + 2);
   localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

   state_t              state;
   logic [2:0]          last_grant;
   logic [GW-1:0]       gap_cnt;

   logic                win_found;
   logic [2:0]          win_idx;
   logic [7:0]          win_data;
   logic [NUM_REQ-1:0]  win_oh;
   logic [NUM_REQ-1:0]  owner_oh;
   logic                tmo_expire;

   // Round-robin search: first set req bit starting at last_grant+1, wrapping mod NUM_REQ.
   always_comb begin
      logic [3:0] pos;
      pos       = '0;
      win_found = 1'b0;
      win_idx   = last_grant;
      for (int off = 1; off <= NUM_REQ; off++) begin
         pos = {1'b0, last_grant} + 4'(off);
         if (pos >= 4'(NUM_REQ)) begin
            pos = pos - 4'(NUM_REQ);
         end
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!win_found && req[j] && (pos[2:0] == 3'(j))) begin
               win_found = 1'b1;
               win_idx   = 3'(j);
            end
         end
      end
   end

   // Winner's byte and one-hot vectors for the grant and completion pulses.
   always_comb begin
      win_data = '0;
      win_oh   = '0;
      owner_oh = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (win_idx == 3'(j)) begin
            win_data  = req_data[8*j +: 8];
            win_oh[j] = 1'b1;
         end
         if (owner == 3'(j)) begin
            owner_oh[j] = 1'b1;
         end
      end
   end

`ifdef UART_TX_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   logic [TW-1:0] tmo_cnt;

   // BUSY watchdog: loaded in LOAD so BUSY cycle 1 holds TIMEOUT_CYC-1; terminal count 0 is BUSY cycle TIMEOUT_CYC.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt <= '0;
      end else if (state == S_LOAD) begin
         tmo_cnt <= TW'(TIMEOUT_CYC - 1);
      end else if ((state == S_BUSY) && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - 1'b1;
      end
   end

   assign tmo_expire = (tmo_cnt == '0);
`else
   // Watchdog compiled out: TIMEOUT_CYC is a positive count, so this never expires.
   assign tmo_expire = (TIMEOUT_CYC < 0);
`endif

   // Scheduler FSM with all outputs registered; pulse outputs default low every cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= S_IDLE;
         last_grant      <= 3'(NUM_REQ - 1);
         gap_cnt         <= '0;
         gnt             <= '0;
         cpl             <= '0;
         busy            <= 1'b0;
         owner           <= '0;
         tx_data         <= '0;
         tx_data_bit_num <= '0;
         tx_stop_bit_num <= 1'b0;
         tx_parity_en    <= 1'b0;
         tx_parity_type  <= 1'b0;
         tx_start        <= 1'b0;
         timeout_err     <= 1'b0;
      end else begin
         gnt         <= '0;
         cpl         <= '0;
         tx_start    <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (enable && win_found) begin
                  state           <= S_LOAD;
                  gnt             <= win_oh;
                  tx_start        <= 1'b1;
                  busy            <= 1'b1;
                  owner           <= win_idx;
                  last_grant      <= win_idx;
                  tx_data         <= win_data;
                  tx_data_bit_num <= cfg_data_bits;
                  tx_stop_bit_num <= cfg_stop2;
                  tx_parity_en    <= cfg_parity_en;
                  tx_parity_type  <= cfg_parity_even;
               end
            end
            S_LOAD: begin
               state <= S_BUSY;
            end
            S_BUSY: begin
               // tx_done takes precedence over a watchdog expiry in the same cycle.
               if (tx_done) begin
                  cpl <= owner_oh;
               end else if (tmo_expire) begin
                  timeout_err <= 1'b1;
               end
               if (tx_done || tmo_expire) begin
                  if (GAP_CYCLES == 0) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state   <= S_GAP;
                     gap_cnt <= GAP_LOAD;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  gap_cnt <= gap_cnt - 1'b1;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler (NUM_REQ=4, GAP_CYCLES=16, TIMEOUT_CYC=4096).
// Inputs change 1 ns after a rising edge; outputs are sampled on falling edges.

module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        enable;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [1:0]  cfg_data_bits;
   logic        cfg_stop2;
   logic        cfg_parity_en;
   logic        cfg_parity_even;
   logic [3:0]  gnt;
   logic [3:0]  cpl;
   logic        busy;
   logic [2:0]  owner;
   logic [7:0]  tx_data;
   logic [1:0]  tx_data_bit_num;
   logic        tx_stop_bit_num;
   logic        tx_parity_en;
   logic        tx_parity_type;
   logic        tx_start;
   logic        tx_done;
   logic        timeout_err;

   int errors = 0;
   int checks = 0;

   uart_tx_scheduler #(
      .NUM_REQ     (4),
      .GAP_CYCLES  (16),
      .TIMEOUT_CYC (4096)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .req             (req),
      .req_data        (req_data),
      .cfg_data_bits   (cfg_data_bits),
      .cfg_stop2       (cfg_stop2),
      .cfg_parity_en   (cfg_parity_en),
      .cfg_parity_even (cfg_parity_even),
      .gnt             (gnt),
      .cpl             (cpl),
      .busy            (busy),
      .owner           (owner),
      .tx_data         (tx_data),
      .tx_data_bit_num (tx_data_bit_num),
      .tx_stop_bit_num (tx_stop_bit_num),
      .tx_parity_en    (tx_parity_en),
      .tx_parity_type  (tx_parity_type),
      .tx_start        (tx_start),
      .tx_done         (tx_done),
      .timeout_err     (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(posedge clk);
      #1 reset_n = 1'b0;
      enable = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
      cfg_data_bits = 2'b11; cfg_stop2 = 1'b0; cfg_parity_en = 1'b0; cfg_parity_even = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   // Called on a falling edge; returns on the falling edge where gnt is seen, or after limit edges.
   task automatic wait_gnt(input int limit, output int cycles);
      cycles = 0;
      while (gnt === 4'b0000 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   // Called on a falling edge; returns on the falling edge where busy has dropped, or after limit edges.
   task automatic wait_idle(input int limit, output int cycles);
      cycles = 0;
      while (busy !== 1'b0 && cycles < limit) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   // One-cycle tx_done; returns on the falling edge one cycle after the DUT sampled it.
   task automatic pulse_done();
      @(posedge clk);
      #1 tx_done = 1'b1;
      @(posedge clk);
      #1 tx_done = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      enable = 1'b1; req = '0; req_data = '0; tx_done = 1'b0;
      cfg_data_bits = 2'b11; cfg_stop2 = 1'b0; cfg_parity_en = 1'b0; cfg_parity_even = 1'b0;
      #2 reset_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({gnt, cpl, busy, owner, tx_start, timeout_err} !== 15'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %h required 0", {gnt, cpl, busy, owner, tx_start, timeout_err});
      end
      checks++;
      if ({tx_data, tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type} !== 13'd0) begin
         errors++;
         $display("FAIL reset_data: got %h required 0", {tx_data, tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type});
      end
      @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   task automatic test_single();
      int cyc;
      @(posedge clk);
      #1 req = 4'b0001; req_data = 32'h0000_0055;
      @(negedge clk);
      checks++;
      if (gnt !== 4'b0000) begin errors++; $display("FAIL single_early_gnt: got %b required 0000", gnt); end
      @(negedge clk);
      checks++;
      if ({gnt, tx_start, busy, owner} !== {4'b0001, 1'b1, 1'b1, 3'd0}) begin
         errors++;
         $display("FAIL single_load: gnt/start/busy/owner got %b %b %b %0d required 0001 1 1 0", gnt, tx_start, busy, owner);
      end
      checks++;
      if (tx_data !== 8'h55) begin errors++; $display("FAIL single_data: got %h required 55", tx_data); end
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      checks++;
      if ({gnt, tx_start, busy} !== {4'b0000, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL single_busy: gnt/start/busy got %b %b %b required 0000 0 1", gnt, tx_start, busy);
      end
      pulse_done();
      checks++;
      if (cpl !== 4'b0001) begin errors++; $display("FAIL single_cpl: got %b required 0001", cpl); end
      wait_idle(100, cyc);
      checks++;
      if (cyc !== 16) begin errors++; $display("FAIL single_gap: busy low after %0d cycles required 16", cyc); end
   endtask

   task automatic test_round_robin();
      int cyc;
      int exp_w;
      int order[5] = '{0, 1, 2, 3, 0};
      logic [7:0] exp_byte;
      do_reset();
      @(posedge clk);
      #1 req = 4'b1111; req_data = 32'h4433_2211;
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         exp_w = order[k];
         exp_byte = 8'((exp_w + 1) * 17);
         wait_gnt(40, cyc);
         if (k > 0) begin
            checks++;
            if (cyc !== 17) begin errors++; $display("FAIL rr_gap_%0d: cpl to gnt %0d cycles required 17", k, cyc); end
         end
         checks++;
         if (gnt !== 4'(1 << exp_w)) begin errors++; $display("FAIL rr_gnt_%0d: got %b required %b", k, gnt, 4'(1 << exp_w)); end
         checks++;
         if (tx_data !== exp_byte) begin errors++; $display("FAIL rr_data_%0d: got %h required %h", k, tx_data, exp_byte); end
         pulse_done();
         checks++;
         if (cpl !== 4'(1 << exp_w)) begin errors++; $display("FAIL rr_cpl_%0d: got %b required %b", k, cpl, 4'(1 << exp_w)); end
      end
      req = 4'b0000;
      wait_idle(100, cyc);
   endtask

   task automatic test_cfg_latch();
      int cyc;
      @(posedge clk);
      #1 req = 4'b0001; req_data = 32'h0000_00A5;
      cfg_data_bits = 2'b00; cfg_stop2 = 1'b0; cfg_parity_en = 1'b1; cfg_parity_even = 1'b1;
      @(negedge clk);
      wait_gnt(5, cyc);
      checks++;
      if ({gnt, tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type} !== {4'b0001, 5'b00011}) begin
         errors++;
         $display("FAIL cfg_grant: gnt/fmt got %b %b required 0001 00011", gnt, {tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type});
      end
      @(posedge clk);
      #1 req = 4'b0000; req_data = 32'h0000_3CFF;
      cfg_data_bits = 2'b11; cfg_stop2 = 1'b1; cfg_parity_en = 1'b0; cfg_parity_even = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({tx_data, tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type} !== {8'hA5, 5'b00011}) begin
         errors++;
         $display("FAIL cfg_frozen: data/fmt got %h %b required a5 00011", tx_data, {tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type});
      end
      pulse_done();
      checks++;
      if (cpl !== 4'b0001) begin errors++; $display("FAIL cfg_cpl: got %b required 0001", cpl); end
      pulse_done();
      checks++;
      if (cpl !== 4'b0000) begin errors++; $display("FAIL done_in_gap: cpl got %b required 0000", cpl); end
      wait_idle(100, cyc);
      pulse_done();
      checks++;
      if ({cpl, busy} !== 5'b00000) begin errors++; $display("FAIL done_in_idle: cpl/busy got %b %b required 0000 0", cpl, busy); end
      @(posedge clk);
      #1 req = 4'b0010;
      @(negedge clk);
      wait_gnt(5, cyc);
      checks++;
      if ({gnt, tx_data, tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type} !== {4'b0010, 8'h3C, 5'b11100}) begin
         errors++;
         $display("FAIL cfg_next: gnt/data/fmt got %b %h %b required 0010 3c 11100", gnt, tx_data, {tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type});
      end
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      pulse_done();
      wait_idle(100, cyc);
   endtask

   task automatic test_enable();
      int cyc;
      @(posedge clk);
      #1 req = 4'b0001; req_data = 32'h0000_7E01; enable = 1'b1;
      @(negedge clk);
      wait_gnt(5, cyc);
      checks++;
      if (gnt !== 4'b0001) begin errors++; $display("FAIL en_first_gnt: got %b required 0001", gnt); end
      @(posedge clk);
      #1 req = 4'b0010; enable = 1'b0;
      @(negedge clk);
      pulse_done();
      checks++;
      if (cpl !== 4'b0001) begin errors++; $display("FAIL en_cpl: got %b required 0001", cpl); end
      wait_gnt(60, cyc);
      checks++;
      if ({cyc, gnt, busy} !== {32'd60, 4'b0000, 1'b0}) begin
         errors++;
         $display("FAIL en_blocked: waited %0d gnt %b busy %b required 60 0000 0", cyc, gnt, busy);
      end
      @(posedge clk);
      #1 enable = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({gnt, owner, tx_data} !== {4'b0010, 3'd1, 8'h7E}) begin
         errors++;
         $display("FAIL en_resume: gnt/owner/data got %b %0d %h required 0010 1 7e", gnt, owner, tx_data);
      end
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      pulse_done();
      checks++;
      if ({cpl, timeout_err} !== 5'b00100) begin errors++; $display("FAIL en_cpl2: cpl/timeout_err got %b %b required 0010 0", cpl, timeout_err); end
      wait_idle(100, cyc);
   endtask

   task automatic test_reset_mid_frame();
      int cyc;
      @(posedge clk);
      #1 req = 4'b0100; req_data = 32'h0099_0000;
      @(negedge clk);
      wait_gnt(5, cyc);
      checks++;
      if ({gnt, owner} !== {4'b0100, 3'd2}) begin errors++; $display("FAIL rst_pre_gnt: gnt/owner got %b %0d required 0100 2", gnt, owner); end
      @(posedge clk);
      #1 req = 4'b0000;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, owner, tx_data, tx_data_bit_num, tx_stop_bit_num, tx_parity_en, tx_parity_type, gnt, cpl, tx_start} !== 30'd0) begin
         errors++;
         $display("FAIL rst_async: busy/owner/data got %b %0d %h required 0 0 00", busy, owner, tx_data);
      end
      @(posedge clk);
      #1 reset_n = 1'b1; req = 4'b1001; req_data = 32'hD000_00C0;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({gnt, owner, tx_data} !== {4'b0001, 3'd0, 8'hC0}) begin
         errors++;
         $display("FAIL rst_regrant: gnt/owner/data got %b %0d %h required 0001 0 c0", gnt, owner, tx_data);
      end
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      pulse_done();
      checks++;
      if (cpl !== 4'b0001) begin errors++; $display("FAIL rst_cpl: got %b required 0001", cpl); end
      wait_idle(100, cyc);
   endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      @(posedge clk);
      #1 req = 4'b0010; req_data = 32'h0000_6600;
      @(negedge clk);
      wait_gnt(5, cyc);
      checks++;
      if (gnt !== 4'b0010) begin errors++; $display("FAIL tmo_gnt: got %b required 0010", gnt); end
      cyc = 0;
      while (timeout_err !== 1'b1 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (cyc !== 4097) begin errors++; $display("FAIL tmo_when: LOAD to timeout_err %0d cycles required 4097", cyc); end
      checks++;
      if ({cpl, busy} !== 5'b00001) begin errors++; $display("FAIL tmo_nocpl: cpl/busy got %b %b required 0000 1", cpl, busy); end
      @(negedge clk);
      checks++;
      if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: timeout_err still %b required 0", timeout_err); end
      wait_gnt(40, cyc);
      checks++;
      if ({cyc, gnt} !== {32'd16, 4'b0010}) begin errors++; $display("FAIL tmo_regrant: after %0d cycles gnt %b required 16 0010", cyc, gnt); end
      @(posedge clk);
      #1 req = 4'b0000;
      @(negedge clk);
      pulse_done();
      checks++;
      if ({cpl, timeout_err} !== 5'b00100) begin errors++; $display("FAIL tmo_recover: cpl/err got %b %b required 0010 0", cpl, timeout_err); end
      wait_idle(100, cyc);
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, got time %0t required < 500000", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_cfg_latch();
      test_enable();
      test_reset_mid_frame();
`ifdef UART_TX_SCHED_TIMEOUT_EN
      test_timeout();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
